des_key_schedule: RTL and testbench

Sequential DES round-key generator: accepts a 64-bit key, applies PC-1, and emits the sixteen 48-bit round subkeys one per handshake. Order is K1..K16 for encryption and K16..K1 for decryption. It drives the `Keyin` input of the combinational F-function datapath and sits between the key register and the round controller of the DES core.

---
 rtl/des_pkg.sv | 45 ++++
 rtl/des_pc2.sv | 10 +
 rtl/des_key_schedule.sv | 68 ++++++
 tb/tb_des_key_schedule.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule tables, widths, FSM states and C/D rotation helpers
// Ports: none (package).
package des_pkg;
  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  typedef enum logic {IDLE, RUN} state_e;
  // DES bit numbers, 1 = MSB of the source vector
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  // Entry i is the shift applied when leaving output position i
  localparam logic [1:0] LS [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                     2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] RS [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                     2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] h, input logic [1:0] n,
                                              input logic right);
    return right ? (n == 2'd2 ? {h[1:0], h[27:2]} : n == 2'd1 ? {h[0], h[27:1]} : h)
                 : (n == 2'd2 ? {h[25:0], h[27:26]} : n == 2'd1 ? {h[26:0], h[27]} : h);
  endfunction
  // One schedule step on both halves: left for encrypt, right for decrypt
  function automatic logic [2*HALF_W-1:0] step(input logic [2*HALF_W-1:0] cd, input logic dec,
                                               input logic [3:0] idx);
    return {rot28(cd[2*HALF_W-1:HALF_W], dec ? RS[idx] : LS[idx], dec),
            rot28(cd[HALF_W-1:0], dec ? RS[idx] : LS[idx], dec)};
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC-2 permutation, 56-bit C/D to 48-bit round subkey
// Ports: cd_i = {C, D} with DES bit 1 at the MSB; subkey_o = PC-2 result, bit 1 at the MSB.
module des_pc2 import des_pkg::*; (
  input  logic [2*HALF_W-1:0] cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey_o[SUBKEY_W-1-i] = cd_i[2*HALF_W-PC2[i]];
  end
endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES round-key generator, one subkey per handshake
// Ports: clk/rst_n (async active-low); key_valid/key_ready/key_in/decrypt = key intake;
//        subkey_valid/subkey_ready/subkey = subkey stream; round_idx = transfer position;
//        last = 16th subkey; busy = sequence in progress.
module des_key_schedule import des_pkg::*; #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                decrypt,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          round_idx,
  output logic                last,
  output logic                busy
);
  if (NUM_ROUNDS != 16) begin : g_bad_rounds
    $error("des_key_schedule: NUM_ROUNDS must be 16");
  end
  state_e                state_q, state_d;
  logic [2*HALF_W-1:0]   cd_q, cd_d, pc1_key;
  logic                  dec_q, dec_d, last_q, accept, xfer;
  logic [3:0]            idx_q, idx_d;
  logic [SUBKEY_W-1:0]   subkey_q, pc2_out;
  for (genvar i = 0; i < 2*HALF_W; i++) begin : g_pc1
    assign pc1_key[2*HALF_W-1-i] = key_in[KEY_W-PC1[i]];
  end
  always_comb begin
    accept  = key_valid && state_q == IDLE;
    xfer    = state_q == RUN && subkey_ready;
    state_d = accept ? RUN : (xfer && last_q) ? IDLE : state_q;
    dec_d   = accept ? decrypt : dec_q;
    cd_d    = accept ? pc1_key : xfer ? step(cd_q, dec_q, idx_q) : cd_q;
    idx_d   = accept ? 4'd0 : xfer ? idx_q + 4'd1 : idx_q;
  end
  // The presented subkey is always one schedule step ahead of the stored halves
  des_pc2 u_pc2 (
    .cd_i    (step(cd_d, dec_d, idx_d)),
    .subkey_o(pc2_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cd_q     <= '0;
      dec_q    <= 1'b0;
      idx_q    <= '0;
      subkey_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      dec_q    <= dec_d;
      idx_q    <= idx_d;
      last_q   <= state_d == RUN && idx_d == 4'd15;
      if (accept || (xfer && !last_q)) subkey_q <= pc2_out;
    end
  end
  assign key_ready    = state_q == IDLE;
  assign busy         = state_q == RUN;
  assign subkey_valid = state_q == RUN;
  assign subkey       = subkey_q;
  assign round_idx    = idx_q;
  assign last         = last_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1 key
module tb_des_key_schedule;
  logic        clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0, decrypt = 1'b0, subkey_ready = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_ready, subkey_valid, last, busy;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  typedef struct packed {logic [47:0] sk; logic [3:0] idx; logic lst;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KENC [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .decrypt(decrypt), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready), .subkey(subkey),
    .round_idx(round_idx), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_seq(input logic dec);
    for (int i = 0; i < 16; i++)
      sb.push_back('{sk: dec ? KENC[15-i] : KENC[i], idx: 4'(i), lst: (i == 15)});
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (!key_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int c = 0;
    while (round_idx != target && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_round_idx", {60'h0, round_idx}, {60'h0, target});
  endtask

  // Called just after a rising edge; returns just after the accept edge
  task automatic send(input logic [63:0] k, input logic dec);
    int c;
    wait_idle(c);
    chk("key_ready_before_send", {63'h0, key_ready}, 64'h1);
    key_in = k; decrypt = dec; key_valid = 1'b1;
    @(posedge clk);
    push_seq(dec);
    #1 key_valid = 1'b0; key_in = '0; decrypt = 1'b0;
  endtask

  // Monitor: every transfer the DUT is about to make is matched against the queue
  initial forever begin
    @(negedge clk);
    if (subkey_valid && subkey_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_subkey: got %h with nothing expected", subkey);
      end else begin
        e = sb.pop_front();
        chk("subkey", {16'h0, subkey}, {16'h0, e.sk});
        chk("round_idx", {60'h0, round_idx}, {60'h0, e.idx});
        chk("last", {63'h0, last}, {63'h0, e.lst});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    #12;
    chk("rst_key_ready", {63'h0, key_ready}, 64'h1);
    chk("rst_subkey_valid", {63'h0, subkey_valid}, 64'h0);
    chk("rst_subkey", {16'h0, subkey}, 64'h0);
    chk("rst_round_idx", {60'h0, round_idx}, 64'h0);
    chk("rst_last", {63'h0, last}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // encrypt, ready tied high
    send(KEY, 1'b0);
    chk("accept_busy", {63'h0, busy}, 64'h1);
    chk("accept_key_ready", {63'h0, key_ready}, 64'h0);
    chk("accept_first_valid", {63'h0, subkey_valid}, 64'h1);
    wait_idle(cyc);
    chk("enc_ready_latency", 64'(cyc), 64'd16);
    chk("enc_drained", 64'(sb.size()), 64'd0);
    chk("enc_valid_low", {63'h0, subkey_valid}, 64'h0);
    // decrypt: exact reverse order
    send(KEY, 1'b1);
    wait_idle(cyc);
    chk("dec_ready_latency", 64'(cyc), 64'd16);
    // parity bits ignored
    send(KEY ^ 64'h0101010101010101, 1'b0);
    wait_idle(cyc);
    // backpressure at position 3
    send(KEY, 1'b0);
    wait_idx(4'd3);
    subkey_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_subkey", {16'h0, subkey}, {16'h0, KENC[3]});
      chk("stall_round_idx", {60'h0, round_idx}, 64'd3);
      chk("stall_last", {63'h0, last}, 64'h0);
    end
    subkey_ready = 1'b1;
    wait_idle(cyc);
    chk("stall_drained", 64'(sb.size()), 64'd0);
    // key_valid pulsed while busy is ignored
    send(KEY, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    key_in = 64'h0123456789ABCDEF; decrypt = 1'b0; key_valid = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0;
    chk("busy_pulse_key_ready", {63'h0, key_ready}, 64'h0);
    chk("busy_pulse_round_idx", {60'h0, round_idx}, 64'd4);
    wait_idle(cyc);
    @(posedge clk); #1;
    chk("busy_pulse_no_extra", {63'h0, subkey_valid}, 64'h0);
    // asynchronous reset mid-sequence
    send(KEY, 1'b0);
    wait_idx(4'd7);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_key_ready", {63'h0, key_ready}, 64'h1);
    chk("midrst_subkey_valid", {63'h0, subkey_valid}, 64'h0);
    chk("midrst_subkey", {16'h0, subkey}, 64'h0);
    chk("midrst_round_idx", {60'h0, round_idx}, 64'h0);
    chk("midrst_last", {63'h0, last}, 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(KEY, 1'b0);
    chk("post_rst_first", {16'h0, subkey}, {16'h0, KENC[0]});
    wait_idle(cyc);
    chk("post_rst_latency", 64'(cyc), 64'd16);
    @(posedge clk); #1;
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
